// File: rtl/axi3_mem_slave.sv
// axi3_mem_slave
//   AXI3 slave terminating a master port on an on-chip word memory, so the
//   master can be simulated and brought up stand-alone with real data paths.
//   Independent write (AW/W/B) and read (AR/R) state machines.
//
// Parameters: DATA_W (bus width, pow2 >= 32), ADDR_W, ID_W,
//             MEM_DEPTH (words, pow2).
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   S_AXI_AW*             - write address (LOCK/CACHE/PROT/QOS ignored)
//   S_AXI_W*              - write data (WID ignored; burst ends on beat count)
//   S_AXI_B*              - write response
//   S_AXI_AR*             - read address (LOCK/CACHE/PROT/QOS ignored)
//   S_AXI_R*              - read data
// Optional feature: define AXI3_MEM_SLAVE_ERR_CHECK_EN to report SLVERR on
//   WLAST misplacement or on AxSIZE not equal to the full bus width.
module axi3_mem_slave #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 6,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ID_W-1:0]     S_AXI_AWID,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [3:0]          S_AXI_AWLEN,
    input  logic [2:0]          S_AXI_AWSIZE,
    input  logic [1:0]          S_AXI_AWBURST,
    input  logic [1:0]          S_AXI_AWLOCK,
    input  logic [3:0]          S_AXI_AWCACHE,
    input  logic [2:0]          S_AXI_AWPROT,
    input  logic [3:0]          S_AXI_AWQOS,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [ID_W-1:0]     S_AXI_WID,
    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WLAST,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [ID_W-1:0]     S_AXI_BID,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ID_W-1:0]     S_AXI_ARID,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [3:0]          S_AXI_ARLEN,
    input  logic [2:0]          S_AXI_ARSIZE,
    input  logic [1:0]          S_AXI_ARBURST,
    input  logic [1:0]          S_AXI_ARLOCK,
    input  logic [3:0]          S_AXI_ARCACHE,
    input  logic [2:0]          S_AXI_ARPROT,
    input  logic [3:0]          S_AXI_ARQOS,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [ID_W-1:0]     S_AXI_RID,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RLAST,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [ID_W-1:0]   wid_q, rid_q;
    logic [IDX_W-1:0]  widx_q, ridx_q, widx_cur, ridx_cur;
    logic [3:0]        wlen_q, wbeat_q, rlen_q, rbeat_q;
    logic              wfixed_q, rfixed_q, werr_q, rerr_q, rlast_q;
    logic [DATA_W-1:0] rdata_q;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic              aw_err, w_err, ar_err;

    // Ready outputs decode the state and are forced low while in reset.
    assign S_AXI_AWREADY = (wstate == W_IDLE)  && !reset;
    assign S_AXI_WREADY  = (wstate == W_DATA)  && !reset;
    assign S_AXI_BVALID  = (wstate == W_RESP)  && !reset;
    assign S_AXI_ARREADY = (rstate == R_IDLE)  && !reset;
    assign S_AXI_RVALID  = (rstate == R_DATA)  && !reset;

    assign S_AXI_BID   = wid_q;
    assign S_AXI_BRESP = {werr_q, 1'b0};
    assign S_AXI_RID   = rid_q;
    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = {rerr_q, 1'b0};
    assign S_AXI_RLAST = rlast_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign b_hs  = S_AXI_BVALID  && S_AXI_BREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;

    // FIXED bursts hold the index; INCR and WRAP both just increment and
    // wrap modulo the memory depth through the natural index width.
    assign widx_cur = widx_q + (wfixed_q ? '0 : IDX_W'(wbeat_q));
    assign ridx_cur = ridx_q + (rfixed_q ? '0 : IDX_W'(rbeat_q));

`ifdef AXI3_MEM_SLAVE_ERR_CHECK_EN
    assign aw_err = (S_AXI_AWSIZE != 3'(ADDR_LSB));
    assign w_err  = (S_AXI_WLAST != (wbeat_q == wlen_q));
    assign ar_err = (S_AXI_ARSIZE != 3'(ADDR_LSB));
`else
    assign aw_err = 1'b0;
    assign w_err  = 1'b0;
    assign ar_err = 1'b0;
`endif

    // Write FSM
    always_ff @(posedge clk) begin
        if (reset) wstate <= W_IDLE;
        else       wstate <= wstate_nxt;
    end

    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_IDLE:  if (aw_hs) wstate_nxt = W_DATA;
            W_DATA:  if (w_hs && (wbeat_q == wlen_q)) wstate_nxt = W_RESP;
            W_RESP:  if (b_hs) wstate_nxt = W_IDLE;
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wid_q    <= '0;
            widx_q   <= '0;
            wlen_q   <= '0;
            wbeat_q  <= '0;
            wfixed_q <= 1'b0;
            werr_q   <= 1'b0;
        end else if (aw_hs) begin
            wid_q    <= S_AXI_AWID;
            widx_q   <= S_AXI_AWADDR[ADDR_LSB +: IDX_W];
            wlen_q   <= S_AXI_AWLEN;
            wbeat_q  <= '0;
            wfixed_q <= (S_AXI_AWBURST == 2'b00);
            werr_q   <= aw_err;
        end else if (w_hs) begin
            wbeat_q  <= wbeat_q + 4'd1;
            werr_q   <= werr_q | w_err;
        end
    end

    // Memory write port; no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) mem[widx_cur][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    // Read FSM
    always_ff @(posedge clk) begin
        if (reset) rstate <= R_IDLE;
        else       rstate <= rstate_nxt;
    end

    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            R_IDLE:  if (ar_hs) rstate_nxt = R_FETCH;
            R_FETCH: rstate_nxt = R_DATA;
            R_DATA:  if (r_hs) rstate_nxt = rlast_q ? R_IDLE : R_FETCH;
            default: rstate_nxt = R_IDLE;
        endcase
    end

    // Read datapath. The memory read lands in rdata_q only in R_FETCH, so
    // R outputs hold steady through any RREADY stall. A same-edge write to
    // the same word is not visible here (read-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            rid_q    <= '0;
            ridx_q   <= '0;
            rlen_q   <= '0;
            rbeat_q  <= '0;
            rfixed_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
        end else begin
            if (ar_hs) begin
                rid_q    <= S_AXI_ARID;
                ridx_q   <= S_AXI_ARADDR[ADDR_LSB +: IDX_W];
                rlen_q   <= S_AXI_ARLEN;
                rbeat_q  <= '0;
                rfixed_q <= (S_AXI_ARBURST == 2'b00);
                rerr_q   <= ar_err;
            end
            if (rstate == R_FETCH) begin
                rdata_q <= mem[ridx_cur];
                rlast_q <= (rbeat_q == rlen_q);
            end
            if (r_hs) rbeat_q <= rbeat_q + 4'd1;
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
                         S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_WID, S_AXI_WLAST,
                         S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
                         S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS};
endmodule

// File: tb/tb_axi3_mem_slave.sv
`timescale 1ns/1ps
module tb_axi3_mem_slave;
    localparam int DATA_W = 64, ADDR_W = 32, ID_W = 6, MEM_DEPTH = 1024;
`ifdef AXI3_MEM_SLAVE_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1;
    logic [ID_W-1:0] awid = '0, wid = '0, arid = '0, bid, rid;
    logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
    logic [3:0] awlen = '0, arlen = '0;
    logic [2:0] awsize = 3'd3, arsize = 3'd3;
    logic [1:0] awburst = 2'b01, arburst = 2'b01, bresp, rresp;
    logic awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
    logic arvalid = 0, arready, rlast, rvalid, rready = 0;
    logic [DATA_W-1:0] wdata = '0, rdata;
    logic [DATA_W/8-1:0] wstrb = '0;

    axi3_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(2'b00), .S_AXI_AWCACHE(4'h0), .S_AXI_AWPROT(3'h0),
        .S_AXI_AWQOS(4'h0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WID(wid), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
        .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(2'b00), .S_AXI_ARCACHE(4'h0), .S_AXI_ARPROT(3'h0),
        .S_AXI_ARQOS(4'h0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } bexp_t;
    typedef struct { logic [63:0] data; logic last; logic [1:0] resp; logic [ID_W-1:0] id; } rexp_t;
    bexp_t bq[$];
    rexp_t rq[$];
    logic [63:0] ref_mem [MEM_DEPTH];
    logic [63:0] wq [16];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Drives one write burst; reference memory and the expected B response
    // are updated when the stimulus is issued.
    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [7:0] strb, input int last_beat,
                            input int bready_delay);
        int n, idx, aw_t, b_t;
        bit tmo;
        bexp_t e;
        tmo = 0;
        for (int b = 0; b <= len; b++) begin
            idx = (int'(addr >> 3) + ((burst == 2'b00) ? 0 : b)) % MEM_DEPTH;
            for (int k = 0; k < 8; k++) if (strb[k]) ref_mem[idx][k*8 +: 8] = wq[b][k*8 +: 8];
        end
        e.id = id;
        e.resp = (ERR_EN && last_beat != len) ? 2'b10 : 2'b00;
        bq.push_back(e);

        awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'd3; awburst = burst; awvalid = 1;
        n = 0; while (!awready && n < 50) begin tick(); n++; end
        if (!awready) tmo = 1;
        aw_t = cyc;
        tick(); awvalid = 0;
        for (int b = 0; b <= len; b++) begin
            wdata = wq[b]; wstrb = strb; wlast = (b == last_beat); wvalid = 1;
            n = 0; while (!wready && n < 50) begin tick(); n++; end
            if (!wready) tmo = 1;
            tick();
        end
        wvalid = 0; wlast = 0;
        n = 0; while (!bvalid && n < 50) begin tick(); n++; end
        if (!bvalid) tmo = 1;
        b_t = cyc;
        checks++;
        if (tmo) begin failures++; $display("FAIL write_timeout id=%0h addr=%0h", id, addr); end
        checks++;
        if (b_t - aw_t !== len + 2) begin
            failures++; $display("FAIL bvalid_latency got=%0d exp=%0d", b_t - aw_t, len + 2);
        end
        for (int d = 0; d < bready_delay; d++) begin
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0) begin
                failures++; $display("FAIL b_hold cycle=%0d bvalid=%b awready=%b exp 1/0", d, bvalid, awready);
            end
            tick();
        end
        bready = 1;
        e = bq.pop_front();
        checks++;
        if (bvalid !== 1'b1 || bid !== e.id || bresp !== e.resp) begin
            failures++;
            $display("FAIL b_resp got v=%b id=%0h resp=%b exp v=1 id=%0h resp=%b", bvalid, bid, bresp, e.id, e.resp);
        end
        tick(); bready = 0;
        checks++;
        if (awready !== 1'b1) begin failures++; $display("FAIL awready_after_b got=%b exp=1", awready); end
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [2:0] size, input bit stall);
        int n, idx, ar_t, hs_t, k;
        rexp_t r;
        for (int b = 0; b <= len; b++) begin
            idx = (int'(addr >> 3) + ((burst == 2'b00) ? 0 : b)) % MEM_DEPTH;
            r.data = ref_mem[idx]; r.last = (b == len); r.id = id;
            r.resp = (ERR_EN && size != 3'd3) ? 2'b10 : 2'b00;
            rq.push_back(r);
        end
        arid = id; araddr = addr; arlen = 4'(len); arsize = size; arburst = burst; arvalid = 1;
        n = 0; while (!arready && n < 50) begin tick(); n++; end
        checks++;
        if (!arready) begin failures++; $display("FAIL ar_timeout got=0 exp=1"); end
        ar_t = cyc;
        hs_t = 0;
        tick(); arvalid = 0;
        for (int b = 0; b <= len; b++) begin
            n = 0; while (!rvalid && n < 50) begin tick(); n++; end
            checks++;
            if (b == 0 && cyc - ar_t !== 2) begin
                failures++; $display("FAIL r_first_latency got=%0d exp=2", cyc - ar_t);
            end else if (b != 0 && cyc - hs_t !== 2) begin
                failures++; $display("FAIL r_beat_gap beat=%0d got=%0d exp=2", b, cyc - hs_t);
            end
            if (stall) begin
                k = $urandom_range(0, 3);
                for (int d = 0; d < k; d++) begin
                    checks++;
                    if (rvalid !== 1'b1 || rdata !== rq[0].data) begin
                        failures++; $display("FAIL r_stable got v=%b d=%h exp v=1 d=%h", rvalid, rdata, rq[0].data);
                    end
                    tick();
                end
            end
            rready = 1;
            r = rq.pop_front();
            checks++;
            if (rvalid !== 1'b1 || rdata !== r.data || rlast !== r.last || rid !== r.id || rresp !== r.resp) begin
                failures++;
                $display("FAIL r_beat%0d got v=%b d=%h last=%b id=%0h resp=%b exp v=1 d=%h last=%b id=%0h resp=%b",
                         b, rvalid, rdata, rlast, rid, rresp, r.data, r.last, r.id, r.resp);
            end
            hs_t = cyc;
            tick(); rready = 0;
        end
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            failures++; $display("FAIL arready_after_last got ar=%b rv=%b exp 1/0", arready, rvalid);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) tick();
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || rdata !== '0 || bid !== '0 || rlast !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got aw=%b w=%b b=%b ar=%b r=%b rd=%h exp all 0",
                     awready, wready, bvalid, arready, rvalid, rdata);
        end
        reset = 0;
        tick();
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            failures++; $display("FAIL ready_after_reset got aw=%b ar=%b exp 1/1", awready, arready);
        end
    endtask

    task automatic test_single();
        wq[0] = 64'h0123_4567_89AB_CDEF;
        do_write(6'h05, 32'h40, 0, 2'b01, 8'hFF, 0, 0);
        do_read(6'h09, 32'h40, 0, 2'b01, 3'd3, 0);
    endtask

    task automatic test_incr16();
        for (int i = 0; i < 16; i++) wq[i] = 64'(i);
        do_write(6'h11, 32'h1000, 15, 2'b01, 8'hFF, 15, 5);
        do_read(6'h12, 32'h1000, 15, 2'b01, 3'd3, 0);
    endtask

    task automatic test_strobe();
        wq[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(6'h01, 32'h200, 0, 2'b01, 8'hFF, 0, 0);
        wq[0] = 64'h1122_3344_5566_7788;
        do_write(6'h02, 32'h200, 0, 2'b01, 8'h0F, 0, 0);
        checks++;
        if (ref_mem[64] !== 64'hFFFF_FFFF_5566_7788) begin
            failures++; $display("FAIL strobe_model got=%h exp=ffffffff55667788", ref_mem[64]);
        end
        do_read(6'h03, 32'h200, 0, 2'b01, 3'd3, 0);
    endtask

    task automatic test_wrap_fixed();
        for (int i = 0; i < 4; i++) wq[i] = 64'hA000_0000_0000_0000 + 64'(i);
        do_write(6'h21, 32'h1FF0, 3, 2'b10, 8'hFF, 3, 0);
        do_read(6'h22, 32'h1FF0, 3, 2'b01, 3'd3, 0);
        do_read(6'h23, 32'h0, 1, 2'b01, 3'd3, 0);
        wq[0] = 64'h5555_5555_5555_5555;
        do_write(6'h24, 32'h1808, 0, 2'b01, 8'hFF, 0, 0);
        for (int i = 0; i < 4; i++) wq[i] = 64'hB000_0000_0000_0000 + 64'(i);
        do_write(6'h25, 32'h1800, 3, 2'b00, 8'hFF, 3, 0);
        do_read(6'h26, 32'h1800, 1, 2'b01, 3'd3, 0);
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 4; i++) wq[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
        fork
            do_write(6'h31, 32'h400, 3, 2'b01, 8'hFF, 3, 0);
            do_read(6'h32, 32'h1000, 3, 2'b01, 3'd3, 1);
        join
        do_read(6'h33, 32'h400, 3, 2'b01, 3'd3, 1);
    endtask

    task automatic test_reset_mid_read();
        int n;
        arid = 6'h3A; araddr = 32'h1000; arlen = 4'd3; arsize = 3'd3; arburst = 2'b01; arvalid = 1;
        n = 0; while (!arready && n < 50) begin tick(); n++; end
        tick(); arvalid = 0;
        n = 0; while (!rvalid && n < 50) begin tick(); n++; end
        reset = 1;
        tick();
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b0 || awready !== 1'b0) begin
            failures++; $display("FAIL reset_mid_read got rv=%b ar=%b aw=%b exp 0/0/0", rvalid, arready, awready);
        end
        reset = 0;
        tick();
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            failures++; $display("FAIL arready_after_reset got ar=%b rv=%b exp 1/0", arready, rvalid);
        end
        do_read(6'h3B, 32'h40, 0, 2'b01, 3'd3, 0);
    endtask

    task automatic test_err_check();
        for (int i = 0; i < 4; i++) wq[i] = 64'hE000_0000_0000_0000 + 64'(i);
        do_write(6'h15, 32'h600, 3, 2'b01, 8'hFF, 2, 0);
        do_read(6'h16, 32'h600, 3, 2'b01, 3'd3, 0);
        do_read(6'h17, 32'h40, 0, 2'b01, 3'd2, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_incr16();
        test_strobe();
        test_wrap_fixed();
        test_concurrent();
        test_reset_mid_read();
        test_err_check();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
